// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states, flag bit positions.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL   = 3'b000;
   localparam logic [2:0] OP_UMULL = 3'b001;
   localparam logic [2:0] OP_SMULL = 3'b010;
   localparam logic [2:0] OP_UDIV  = 3'b011;
   localparam logic [2:0] OP_SDIV  = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic op_valid(input logic [2:0] o);
      return o <= OP_SDIV;
   endfunction

   function automatic logic op_is_div(input logic [2:0] o);
      return (o == OP_UDIV) || (o == OP_SDIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on the {hi,lo} pair.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           ge;

   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      shifted = {hi, lo[WIDTH-1]};
      // remainder < divisor, so the borrow bit alone tells whether the subtract fits
      diff    = shifted - {1'b0, m};
      ge      = ~diff[WIDTH];
      if (is_div) begin
         hi_nxt = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         lo_nxt = {lo[WIDTH-2:0], ge};
      end else begin
         hi_nxt = sum[WIDTH:1];
         lo_nxt = {sum[0], lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with start/done handshake; one bit per clock, sign fixup at the end.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags,
   output logic             div0
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] acc_hi, acc_lo, m;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic             neg_lo, neg_hi, dz, ovf;

   logic             accept, div_zero_req, signed_op, a_neg, b_neg;
   logic [WIDTH-1:0] op_a, op_b;
   logic [2*WIDTH-1:0] prod, prod_neg;
   logic [WIDTH-1:0] res_lo, res_hi;
   logic [3:0]       res_flags;
   logic             wide;

   assign a_neg        = src_a[WIDTH-1];
   assign b_neg        = src_b[WIDTH-1];
   assign signed_op    = (op == OP_SMULL) || (op == OP_SDIV);
   assign op_a         = (signed_op && a_neg) ? -src_a : src_a;
   assign op_b         = (signed_op && b_neg) ? -src_b : src_b;
   assign div_zero_req = op_is_div(op) && (src_b == '0);
   assign accept       = ((state == ST_IDLE) || (state == ST_DONE)) && start && op_valid(op);

   assign busy = (state == ST_CALC) || (state == ST_FIXUP);
   assign done = (state == ST_DONE);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (op_is_div(op_q)),
      .hi     (acc_hi),
      .lo     (acc_lo),
      .m      (m),
      .hi_nxt (step_hi),
      .lo_nxt (step_lo)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = div_zero_req ? ST_FIXUP : ST_CALC;
         ST_CALC:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_FIXUP;
         ST_FIXUP: state_nxt = ST_DONE;
         ST_DONE: begin
            state_nxt = ST_IDLE;
            if (accept) state_nxt = div_zero_req ? ST_FIXUP : ST_CALC;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_neg = -prod;
      res_lo   = acc_lo;
      res_hi   = acc_hi;
      case (op_q)
         OP_MUL:   res_hi = '0;
         OP_SMULL: {res_hi, res_lo} = neg_lo ? prod_neg : prod;
         OP_SDIV: begin
            res_lo = neg_lo ? -acc_lo : acc_lo;
            res_hi = neg_hi ? -acc_hi : acc_hi;
         end
         default: ;
      endcase
      // divide-by-zero parks the raw dividend in acc_lo
      if (dz) begin
         res_lo = '1;
         res_hi = acc_lo;
      end
      wide      = (op_q == OP_UMULL) || (op_q == OP_SMULL);
      res_flags = '0;
      res_flags[FLAG_N] = wide ? res_hi[WIDTH-1] : res_lo[WIDTH-1];
      res_flags[FLAG_Z] = wide ? ~|{res_hi, res_lo} : ~|res_lo;
      res_flags[FLAG_V] = ovf;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         op_q      <= OP_MUL;
         acc_hi    <= '0;
         acc_lo    <= '0;
         m         <= '0;
         neg_lo    <= 1'b0;
         neg_hi    <= 1'b0;
         dz        <= 1'b0;
         ovf       <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
         flags     <= '0;
         div0      <= 1'b0;
      end else if (accept) begin
         cnt    <= '0;
         op_q   <= op;
         acc_hi <= '0;
         dz     <= div_zero_req;
         ovf    <= (op == OP_SDIV) && (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&src_b);
         neg_lo <= signed_op && (a_neg ^ b_neg);
         neg_hi <= (op == OP_SDIV) && a_neg;
         if (op_is_div(op)) begin
            m      <= op_b;
            acc_lo <= div_zero_req ? src_a : op_a;
         end else begin
            m      <= op_a;
            acc_lo <= op_b;
         end
      end else if (state == ST_CALC) begin
         acc_hi <= step_hi;
         acc_lo <= step_lo;
         cnt    <= cnt + CNT_W'(1);
      end else if (state == ST_FIXUP) begin
         result_lo <= res_lo;
         result_hi <= res_hi;
         flags     <= res_flags;
         div0      <= dz;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8: stimulus pushes expectations, monitors pop on done.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start, busy, done, div0;
   logic [2:0]  op;
   logic [31:0] src_a, src_b, result_lo, result_hi;
   logic [3:0]  flags;

   logic        start8, busy8, done8, div08;
   logic [2:0]  op8;
   logic [7:0]  src_a8, src_b8, result_lo8, result_hi8;
   logic [3:0]  flags8;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
      .flags(flags), .div0(div0));

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .src_a(src_a8), .src_b(src_b8),
      .busy(busy8), .done(done8), .result_lo(result_lo8), .result_hi(result_hi8),
      .flags(flags8), .div0(div08));

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic [3:0]  fl;
      logic        dz;
      int          lat;
      int          start_cyc;
   } exp_t;

   exp_t q32[$];
   exp_t q8[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_tot = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_tot++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp_v, cyc);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (done) begin
         if (q32.size() == 0) chk("spurious_done32", {63'b0, done}, 64'd0);
         else begin
            e = q32.pop_front();
            chk("lo32", {32'b0, result_lo}, {32'b0, e.lo});
            chk("hi32", {32'b0, result_hi}, {32'b0, e.hi});
            chk("flags32", {60'b0, flags}, {60'b0, e.fl});
            chk("div0_32", {63'b0, div0}, {63'b0, e.dz});
            chk("latency32", 64'(cyc - e.start_cyc + 1), 64'(e.lat));
         end
      end
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (done8) begin
         if (q8.size() == 0) chk("spurious_done8", {63'b0, done8}, 64'd0);
         else begin
            e = q8.pop_front();
            chk("lo8", {56'b0, result_lo8}, {32'b0, e.lo});
            chk("hi8", {56'b0, result_hi8}, {32'b0, e.hi});
            chk("flags8", {60'b0, flags8}, {60'b0, e.fl});
            chk("div0_8", {63'b0, div08}, {63'b0, e.dz});
            chk("latency8", 64'(cyc - e.start_cyc + 1), 64'(e.lat));
         end
      end
   end

   // b2b=1: caller sits just after the edge that showed done, so start lands in the DONE cycle
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi, input logic [3:0] ef,
                        input logic ed, input int lat, input bit b2b);
      exp_t e;
      if (!b2b) @(negedge clk);
      op = o; src_a = a; src_b = b; start = 1'b1;
      if (lat > 0) begin
         e.lo = elo; e.hi = ehi; e.fl = ef; e.dz = ed; e.lat = lat; e.start_cyc = cyc + 1;
         q32.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'h0BAD_F00D; op = OP_UDIV;
   endtask

   task automatic issue8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] elo, input logic [7:0] ehi, input logic [3:0] ef,
                         input int lat);
      exp_t e;
      @(negedge clk);
      op8 = o; src_a8 = a; src_b8 = b; start8 = 1'b1;
      e.lo = {24'b0, elo}; e.hi = {24'b0, ehi}; e.fl = ef; e.dz = 1'b0; e.lat = lat; e.start_cyc = cyc + 1;
      q8.push_back(e);
      @(posedge clk); #1;
      start8 = 1'b0; src_a8 = 8'h5A; src_b8 = 8'hA5;
   endtask

   task automatic wait_done32();
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (done) return;
      end
      chk("wait_done_timeout", {63'b0, done}, 64'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (q32.size() == 0 && q8.size() == 0 && !busy && !busy8 && !done && !done8) return;
      end
      chk("drain_timeout", 64'(q32.size() + q8.size()), 64'd0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_busy"},  {63'b0, busy}, 64'd0);
      chk({tag, "_done"},  {63'b0, done}, 64'd0);
      chk({tag, "_lo"},    {32'b0, result_lo}, 64'd0);
      chk({tag, "_hi"},    {32'b0, result_hi}, 64'd0);
      chk({tag, "_flags"}, {60'b0, flags}, 64'd0);
      chk({tag, "_div0"},  {63'b0, div0}, 64'd0);
   endtask

   initial begin
      int bc;
      reset = 1'b0; start = 1'b0; op = OP_MUL; src_a = '0; src_b = '0;
      start8 = 1'b0; op8 = OP_MUL; src_a8 = '0; src_b8 = '0;
      repeat (3) @(posedge clk);
      #1 chk_reset_state("rst");
      @(negedge clk) reset = 1'b1;

      // UMULL max x max, with busy-cycle count
      issue(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b1000, 1'b0, 34, 1'b0);
      bc = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         if (busy) bc++;
         @(posedge clk); #1;
      end
      chk("busy_cycles", 64'(bc), 64'd33);
      drain();

      issue(OP_SMULL, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 4'b1000, 1'b0, 34, 1'b0);
      drain();
      issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 4'b0100, 1'b0, 34, 1'b0);
      drain();

      // SDIV -7/2, then UDIV 100/7 started in the DONE cycle
      issue(OP_SDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1000, 1'b0, 34, 1'b0);
      wait_done32();
      issue(OP_UDIV, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, 1'b0, 34, 1'b1);
      chk("b2b_busy", {63'b0, busy}, 64'd1);
      drain();

      issue(OP_UDIV, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'h0000_0064, 4'b1000, 1'b1, 2, 1'b0);
      drain();
      issue(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 4'b1001, 1'b0, 34, 1'b0);
      drain();

      // start pulse mid-operation must be ignored
      issue(OP_UMULL, 32'd3, 32'd5, 32'd15, 32'd0, 4'b0000, 1'b0, 34, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk); op = OP_UDIV; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      drain();

      // reserved opcode: no start, results held
      @(negedge clk); op = 3'b101; src_a = 32'd1; src_b = 32'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reserved_busy", {63'b0, busy}, 64'd0);
      chk("reserved_hold_lo", {32'b0, result_lo}, 64'd15);

      // reset mid-operation aborts without a done
      issue(OP_UMULL, 32'd7, 32'd9, 32'd0, 32'd0, 4'b0000, 1'b0, 0, 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      #1 chk_reset_state("midrst");
      @(negedge clk) reset = 1'b1;
      repeat (40) @(posedge clk);
      issue(OP_UMULL, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'h0000_0001, 4'b0000, 1'b0, 34, 1'b0);
      drain();

      // WIDTH=8 instance
      issue8(OP_UMULL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000, 10);
      drain();
      issue8(OP_UDIV, 8'd200, 8'd7, 8'd28, 8'd4, 4'b0000, 10);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
